// File: rtl/delay_flow_ctrl.sv
// Credit-based valid/ready sequencer around an external fixed-latency delay line.
// Define DELAY_FLOW_CTRL_STAT_EN to add the o_stall_cnt statistics output.
module delay_flow_ctrl #(
   parameter int pWIDTH = 8,
   parameter int pLAT   = 2,
   parameter int pDEPTH = 4,
   localparam int pCW   = $clog2(pDEPTH + 1)
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_flush,
   input  logic              i_valid,
   output logic              o_ready,
   input  logic [pWIDTH-1:0] i_data,
   output logic              o_pipe_vld,
   output logic [pWIDTH-1:0] o_pipe_data,
   input  logic [pWIDTH-1:0] i_pipe_data,
   output logic              o_valid,
   output logic [pWIDTH-1:0] o_data,
   input  logic              i_ready,
`ifdef DELAY_FLOW_CTRL_STAT_EN
   output logic [15:0]       o_stall_cnt,
`endif
   output logic [pCW-1:0]    o_inflight,
   output logic [pCW-1:0]    o_fifo_cnt
);

   localparam int pAW = (pDEPTH > 1) ? $clog2(pDEPTH) : 1;
   localparam logic [pCW:0]   DEPTH_V   = (pCW + 1)'(pDEPTH);
   localparam logic [pCW-1:0] DEPTH_CW  = pCW'(pDEPTH);
   localparam logic [pAW-1:0] LAST_PTR  = pAW'(pDEPTH - 1);

   logic [pLAT-1:0]   vsr_reg;
   logic [pLAT-1:0]   vsr_shift;
   logic [pLAT-1:0]   vsr_next;
   logic [pCW-1:0]    inflight_reg;
   logic [pCW-1:0]    inflight_next;
   logic [pCW-1:0]    fifo_cnt_reg;
   logic [pCW-1:0]    fifo_cnt_next;
   logic [pAW-1:0]    wr_ptr_reg;
   logic [pAW-1:0]    wr_ptr_next;
   logic [pAW-1:0]    rd_ptr_reg;
   logic [pAW-1:0]    rd_ptr_next;
   logic [pWIDTH-1:0] mem [pDEPTH];
   logic [pCW:0]      occ;
   logic              accept;
   logic              capture;
   logic              pop;

   function automatic logic [pAW-1:0] ptr_inc(input logic [pAW-1:0] p);
      return (p == LAST_PTR) ? '0 : p + pAW'(1);
   endfunction

   // Credits are taken from registered occupancy only, so o_ready never depends on i_valid/i_ready.
   assign occ         = {1'b0, inflight_reg} + {1'b0, fifo_cnt_reg};
   assign o_ready     = (occ < DEPTH_V) && !i_flush;
   assign accept      = i_valid && o_ready;
   assign capture     = vsr_reg[pLAT-1] && !i_flush;
   assign pop         = o_valid && i_ready && !i_flush;

   assign o_pipe_vld  = accept;
   assign o_pipe_data = accept ? i_data : '0;
   assign o_valid     = (fifo_cnt_reg != '0);
   assign o_data      = o_valid ? mem[rd_ptr_reg] : '0;
   assign o_inflight  = inflight_reg;
   assign o_fifo_cnt  = fifo_cnt_reg;

   assign vsr_shift[0] = accept;
   genvar gi;
   generate
      for (gi = 1; gi < pLAT; gi++) begin : g_vsr
         assign vsr_shift[gi] = vsr_reg[gi-1];
      end
   endgenerate

   always_comb begin
      vsr_next      = vsr_shift;
      inflight_next = inflight_reg;
      fifo_cnt_next = fifo_cnt_reg;
      wr_ptr_next   = wr_ptr_reg;
      rd_ptr_next   = rd_ptr_reg;
      if (accept && !capture) begin
         inflight_next = inflight_reg + pCW'(1);
      end else if (!accept && capture) begin
         inflight_next = inflight_reg - pCW'(1);
      end
      if (capture && !pop) begin
         fifo_cnt_next = fifo_cnt_reg + pCW'(1);
      end else if (!capture && pop) begin
         fifo_cnt_next = fifo_cnt_reg - pCW'(1);
      end
      if (capture) begin
         wr_ptr_next = ptr_inc(wr_ptr_reg);
      end
      if (pop) begin
         rd_ptr_next = ptr_inc(rd_ptr_reg);
      end
      // Flush drops tracking; beats still inside the external line come back unmarked.
      if (i_flush) begin
         vsr_next      = '0;
         inflight_next = '0;
         fifo_cnt_next = '0;
         wr_ptr_next   = '0;
         rd_ptr_next   = '0;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         vsr_reg      <= '0;
         inflight_reg <= '0;
         fifo_cnt_reg <= '0;
         wr_ptr_reg   <= '0;
         rd_ptr_reg   <= '0;
      end else begin
         vsr_reg      <= vsr_next;
         inflight_reg <= inflight_next;
         fifo_cnt_reg <= fifo_cnt_next;
         wr_ptr_reg   <= wr_ptr_next;
         rd_ptr_reg   <= rd_ptr_next;
      end
   end

   always_ff @(posedge i_clk) begin
      if (capture) begin
         mem[wr_ptr_reg] <= i_pipe_data;
      end
   end

`ifdef DELAY_FLOW_CTRL_STAT_EN
   logic [15:0] stall_cnt_reg;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         stall_cnt_reg <= '0;
      end else if (i_flush) begin
         stall_cnt_reg <= '0;
      end else if (i_valid && !o_ready && (stall_cnt_reg != 16'hFFFF)) begin
         stall_cnt_reg <= stall_cnt_reg + 16'd1;
      end
   end

   assign o_stall_cnt = stall_cnt_reg;
`endif

   always_ff @(posedge i_clk) begin
      if (i_rst_n && !i_flush) begin
         assert (!(capture && !pop && (fifo_cnt_reg == DEPTH_CW)));
         assert (!(pop && (fifo_cnt_reg == '0)));
         assert (occ <= DEPTH_V);
      end
   end

endmodule

// File: tb/tb_delay_flow_ctrl.sv
// Self-checking bench for delay_flow_ctrl: queue-based reference model, randomized and directed scenarios.
module tb_delay_flow_ctrl;

   localparam int W     = 8;
   localparam int LAT   = 2;
   localparam int DEPTH = 4;
   localparam int CW    = $clog2(DEPTH + 1);
   localparam int CW5   = $clog2(5 + 1);
   localparam logic [24:0] RST_VEC = {1'b1, 1'b0, 8'h00, 3'd0, 3'd0, 1'b0, 8'h00};

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          rst_n;
   logic          flush;
   logic          valid;
   logic [W-1:0]  data;
   logic          ready_dn;
   logic          o_ready, o_valid, o_pipe_vld;
   logic [W-1:0]  o_data, o_pipe_data, pipe_in;
   logic [CW-1:0] o_inflight, o_fifo_cnt;
   logic          r5_ready, r5_valid, r5_pipe_vld;
   logic [W-1:0]  r5_data, r5_pipe_data, r5_pipe_in;
   logic [CW5-1:0] r5_inflight, r5_fifo_cnt;
`ifdef DELAY_FLOW_CTRL_STAT_EN
   logic [15:0]   stall_cnt, r5_stall_cnt;
`endif

   delay_flow_ctrl #(.pWIDTH(W), .pLAT(LAT), .pDEPTH(DEPTH)) u_dut (
      .i_clk(clk), .i_rst_n(rst_n), .i_flush(flush),
      .i_valid(valid), .o_ready(o_ready), .i_data(data),
      .o_pipe_vld(o_pipe_vld), .o_pipe_data(o_pipe_data), .i_pipe_data(pipe_in),
      .o_valid(o_valid), .o_data(o_data), .i_ready(ready_dn),
`ifdef DELAY_FLOW_CTRL_STAT_EN
      .o_stall_cnt(stall_cnt),
`endif
      .o_inflight(o_inflight), .o_fifo_cnt(o_fifo_cnt)
   );

   delay_flow_ctrl #(.pWIDTH(W), .pLAT(LAT), .pDEPTH(5)) u_dut5 (
      .i_clk(clk), .i_rst_n(rst_n), .i_flush(flush),
      .i_valid(valid), .o_ready(r5_ready), .i_data(data),
      .o_pipe_vld(r5_pipe_vld), .o_pipe_data(r5_pipe_data), .i_pipe_data(r5_pipe_in),
      .o_valid(r5_valid), .o_data(r5_data), .i_ready(ready_dn),
`ifdef DELAY_FLOW_CTRL_STAT_EN
      .o_stall_cnt(r5_stall_cnt),
`endif
      .o_inflight(r5_inflight), .o_fifo_cnt(r5_fifo_cnt)
   );

   // External delay lines: LAT plain register stages.
   logic [W-1:0] line  [LAT];
   logic [W-1:0] line5 [LAT];
   assign pipe_in    = line[LAT-1];
   assign r5_pipe_in = line5[LAT-1];
   always @(posedge clk) begin
      line[0]  <= o_pipe_data;
      line5[0] <= r5_pipe_data;
      for (int k = 1; k < LAT; k++) begin
         line[k]  <= line[k-1];
         line5[k] <= line5[k-1];
      end
   end

   logic [24:0] act_vec;
   assign act_vec = {o_ready, o_valid, o_data, o_inflight, o_fifo_cnt, o_pipe_vld, o_pipe_data};

   // Reference model: beats in the line with their capture cycle, then a plain FIFO queue.
   typedef struct {
      logic [W-1:0] d;
      int           cap;
   } fl_t;
   fl_t          ifl_q[$];
   logic [W-1:0] ff_q[$];
   logic [W-1:0] got_q[$];
   int           cyc = 0;
   int           stall_m = 0;
   logic         exp_acc;
   logic [24:0]  exp_vec;
   int           total = 0;
   int           bad = 0;

   task automatic cycle(input logic v, input logic [W-1:0] d, input logic r, input logic f);
      logic         er, ev;
      logic [W-1:0] ed;
      fl_t          e;
      @(negedge clk);
      valid = v; data = d; ready_dn = r; flush = f;
      #1;
      er      = ((ifl_q.size() + ff_q.size()) < DEPTH) && !f;
      ev      = (ff_q.size() != 0);
      ed      = ev ? ff_q[0] : '0;
      exp_acc = v && er;
      exp_vec = {er, ev, ed, CW'(ifl_q.size()), CW'(ff_q.size()), exp_acc, exp_acc ? d : 8'h00};
      if (o_valid && r && !f) begin
         got_q.push_back(o_data);
         $display("beat out cyc=%0d data=%02h", cyc, o_data);
      end
      if (f) begin
         ifl_q.delete();
         ff_q.delete();
         stall_m = 0;
      end else begin
         if (v && !er && stall_m < 65535) stall_m++;
         if (ev && r) void'(ff_q.pop_front());
         if (ifl_q.size() != 0 && ifl_q[0].cap == cyc) begin
            e = ifl_q.pop_front();
            ff_q.push_back(e.d);
         end
         if (exp_acc) begin
            e.d = d;
            e.cap = cyc + LAT;
            ifl_q.push_back(e);
         end
      end
      cyc++;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; flush = 1'b0; valid = 1'b0; data = '0; ready_dn = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      #1;
      total++;
      if (act_vec !== RST_VEC) begin
         bad++;
         $display("FAIL reset_hold got=%h want=%h", act_vec, RST_VEC);
      end
      rst_n = 1'b1;
      cycle(1'b0, 8'h00, 1'b1, 1'b0);
      total++;
      if (act_vec !== RST_VEC || act_vec !== exp_vec) begin
         bad++;
         $display("FAIL reset_release got=%h want=%h", act_vec, RST_VEC);
      end
`ifdef DELAY_FLOW_CTRL_STAT_EN
      total++;
      if (stall_cnt !== 16'd0) begin
         bad++;
         $display("FAIL reset_stall got=%0d want=0", stall_cnt);
      end
`endif
   endtask

   task automatic test_single_beat();
      int pcyc = -1, vcyc = -1, nvld = 0, peak = 0;
      logic [W-1:0] vdat = '0;
      for (int i = 0; i < 20; i++) begin
         cycle(i == 10, (i == 10) ? 8'hA5 : 8'h00, 1'b1, 1'b0);
         total++;
         if (act_vec !== exp_vec) begin
            bad++;
            $display("FAIL single i=%0d got=%h want=%h", i, act_vec, exp_vec);
         end
         if (o_pipe_vld) pcyc = i;
         if (o_valid) begin nvld++; vcyc = i; vdat = o_data; end
         if (int'(o_inflight) > peak) peak = int'(o_inflight);
      end
      total++;
      if (pcyc != 10 || nvld != 1 || vcyc != 13 || vdat !== 8'hA5 || peak != 1) begin
         bad++;
         $display("FAIL single_timing issue=%0d out=%0d n=%0d data=%02h peak=%0d want 10/13/1/a5/1",
                  pcyc, vcyc, nvld, vdat, peak);
      end
   endtask

   task automatic test_stream();
      int idx = 1;
      int r5_low = 0;
      got_q.delete();
      for (int i = 0; i < 70; i++) begin
         cycle(idx <= 16, 8'(idx), 1'b1, 1'b0);
         total++;
         if (act_vec !== exp_vec) begin
            bad++;
            $display("FAIL stream i=%0d got=%h want=%h", i, act_vec, exp_vec);
         end
         if (idx <= 16 && r5_ready !== 1'b1) r5_low++;
         if (exp_acc) idx++;
      end
      total++;
      if (r5_low != 0) begin
         bad++;
         $display("FAIL stream_depth5_ready low_cycles=%0d want=0", r5_low);
      end
      total++;
      if (got_q.size() != 16) begin
         bad++;
         $display("FAIL stream_count got=%0d want=16", got_q.size());
      end else begin
         for (int k = 0; k < 16; k++) begin
            total++;
            if (got_q[k] !== 8'(k + 1)) begin
               bad++;
               $display("FAIL stream_order k=%0d got=%02h want=%02h", k, got_q[k], 8'(k + 1));
            end
         end
      end
   endtask

   task automatic test_backpressure();
      int idx = 1, nacc = 0;
      got_q.delete();
      for (int i = 0; i < 12; i++) begin
         cycle(1'b1, 8'(idx), 1'b0, 1'b0);
         total++;
         if (act_vec !== exp_vec) begin
            bad++;
            $display("FAIL backpr_hold i=%0d got=%h want=%h", i, act_vec, exp_vec);
         end
         if (o_pipe_vld) nacc++;
         if (exp_acc) idx++;
      end
      total++;
      if (nacc != 4 || o_fifo_cnt !== 3'd4 || o_ready !== 1'b0) begin
         bad++;
         $display("FAIL backpr_full acc=%0d cnt=%0d ready=%b want 4/4/0", nacc, o_fifo_cnt, o_ready);
      end
      for (int i = 0; i < 40; i++) begin
         cycle(idx <= 8, 8'(idx), 1'b1, 1'b0);
         total++;
         if (act_vec !== exp_vec) begin
            bad++;
            $display("FAIL backpr_drain i=%0d got=%h want=%h", i, act_vec, exp_vec);
         end
         if (exp_acc) idx++;
      end
      total++;
      if (got_q.size() != 8) begin
         bad++;
         $display("FAIL backpr_count got=%0d want=8", got_q.size());
      end else begin
         for (int k = 0; k < 8; k++) begin
            total++;
            if (got_q[k] !== 8'(k + 1)) begin
               bad++;
               $display("FAIL backpr_order k=%0d got=%02h want=%02h", k, got_q[k], 8'(k + 1));
            end
         end
      end
   endtask

   task automatic test_flush();
      logic [W-1:0] seq_d [6] = '{8'h11, 8'h00, 8'h00, 8'h22, 8'h33, 8'h44};
      logic         seq_v [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
      int           late_vld = 0;
      got_q.delete();
      for (int i = 0; i < 6; i++) begin
         cycle(seq_v[i], seq_d[i], i == 5, i == 5);
         total++;
         if (act_vec !== exp_vec) begin
            bad++;
            $display("FAIL flush_seq i=%0d got=%h want=%h", i, act_vec, exp_vec);
         end
      end
      total++;
      if (o_inflight !== 3'd2 || o_fifo_cnt !== 3'd1 || o_valid !== 1'b1 || o_ready !== 1'b0) begin
         bad++;
         $display("FAIL flush_cycle infl=%0d cnt=%0d vld=%b rdy=%b want 2/1/1/0",
                  o_inflight, o_fifo_cnt, o_valid, o_ready);
      end
      for (int i = 0; i < 6; i++) begin
         cycle(1'b0, 8'h00, 1'b1, 1'b0);
         total++;
         if (act_vec !== exp_vec) begin
            bad++;
            $display("FAIL flush_after i=%0d got=%h want=%h", i, act_vec, exp_vec);
         end
         if (o_valid) late_vld++;
      end
      total++;
      if (late_vld != 0 || got_q.size() != 0) begin
         bad++;
         $display("FAIL flush_discard valid_cycles=%0d delivered=%0d want 0/0", late_vld, got_q.size());
      end
      for (int i = 0; i < 6; i++) begin
         cycle(i == 0, (i == 0) ? 8'h55 : 8'h00, 1'b1, 1'b0);
         total++;
         if (act_vec !== exp_vec) begin
            bad++;
            $display("FAIL flush_next i=%0d got=%h want=%h", i, act_vec, exp_vec);
         end
      end
      total++;
      if (got_q.size() != 1 || got_q[0] !== 8'h55) begin
         bad++;
         $display("FAIL flush_next_beat n=%0d want single 55", got_q.size());
      end
   endtask

   task automatic test_random();
      int simul = 0;
      for (int i = 0; i < 400; i++) begin
         cycle(($urandom_range(0, 3) != 0), 8'($urandom), ($urandom_range(0, 4) != 0),
               ($urandom_range(0, 59) == 0));
         total++;
         if (act_vec !== exp_vec) begin
            bad++;
            $display("FAIL random i=%0d got=%h want=%h", i, act_vec, exp_vec);
         end
         if (exp_acc && o_valid && ready_dn && !flush && u_dut.vsr_reg[LAT-1]) simul++;
      end
      $display("random run: %0d cycles with accept+capture+pop together", simul);
      for (int i = 0; i < 10; i++) begin
         cycle(1'b0, 8'h00, 1'b1, 1'b0);
         total++;
         if (act_vec !== exp_vec) begin
            bad++;
            $display("FAIL random_drain i=%0d got=%h want=%h", i, act_vec, exp_vec);
         end
      end
   endtask

`ifdef DELAY_FLOW_CTRL_STAT_EN
   task automatic test_stall();
      cycle(1'b0, 8'h00, 1'b0, 1'b1);
      for (int i = 0; i < 24; i++) begin
         cycle(1'b1, 8'(i + 8'h80), 1'b0, 1'b0);
         total++;
         if (act_vec !== exp_vec) begin
            bad++;
            $display("FAIL stall_fill i=%0d got=%h want=%h", i, act_vec, exp_vec);
         end
      end
      cycle(1'b0, 8'h00, 1'b0, 1'b0);
      total++;
      if (stall_cnt !== 16'(stall_m) || stall_cnt !== 16'd20) begin
         bad++;
         $display("FAIL stall_count got=%0d want=20", stall_cnt);
      end
      cycle(1'b0, 8'h00, 1'b0, 1'b1);
      cycle(1'b0, 8'h00, 1'b0, 1'b0);
      total++;
      if (stall_cnt !== 16'd0) begin
         bad++;
         $display("FAIL stall_flush got=%0d want=0", stall_cnt);
      end
   endtask
`endif

   task automatic test_reset_mid();
      for (int i = 0; i < 5; i++) begin
         cycle(1'b1, 8'(8'h60 + i), 1'b0, 1'b0);
      end
      @(posedge clk);
      #2;
      valid = 1'b0;
      rst_n = 1'b0;
      #1;
      total++;
      if (act_vec !== RST_VEC) begin
         bad++;
         $display("FAIL reset_mid got=%h want=%h", act_vec, RST_VEC);
      end
`ifdef DELAY_FLOW_CTRL_STAT_EN
      total++;
      if (stall_cnt !== 16'd0) begin
         bad++;
         $display("FAIL reset_mid_stall got=%0d want=0", stall_cnt);
      end
`endif
      ifl_q.delete();
      ff_q.delete();
      stall_m = 0;
      @(negedge clk);
      rst_n = 1'b1;
      got_q.delete();
      for (int i = 0; i < 8; i++) begin
         cycle(i == 0, (i == 0) ? 8'h77 : 8'h00, 1'b1, 1'b0);
         total++;
         if (act_vec !== exp_vec) begin
            bad++;
            $display("FAIL reset_mid_after i=%0d got=%h want=%h", i, act_vec, exp_vec);
         end
      end
      total++;
      if (got_q.size() != 1 || got_q[0] !== 8'h77) begin
         bad++;
         $display("FAIL reset_mid_beat n=%0d want single 77", got_q.size());
      end
   endtask

   initial begin
      test_reset();
      test_single_beat();
      test_stream();
      test_backpressure();
      test_flush();
      test_random();
`ifdef DELAY_FLOW_CTRL_STAT_EN
      test_stall();
`endif
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
